// File: rtl/tone_sequencer.sv
// tone_sequencer: queues notes and plays them one after another, each for a number of ticks followed by a silent gap
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   tick                      one-cycle time-base strobe (ignored in IDLE and LOAD)
//   note_valid/note_ready     push handshake into the note queue (ready = queue not full)
//   note_freq/wave/duty/dur   fields of the offered note
//   start, stop               begin playback / abort playback (queue kept)
//   freq_sel/wave_sel/duty_cyc registered waveform-generator controls
//   gate                      generator output audible
//   busy                      sequencer not IDLE
//   done                      one-cycle pulse when the queue runs out naturally
//   count                     queue occupancy
module tone_sequencer #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16,
   parameter int DUR_WIDTH = 16,
   parameter int DEPTH     = 4,
   parameter int GAP_TICKS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     note_valid,
   output logic                     note_ready,
   input  logic [WIDTH-1:0]         note_freq,
   input  logic                     note_wave,
   input  logic [CNT_WIDTH-1:0]     note_duty,
   input  logic [DUR_WIDTH-1:0]     note_dur,
   input  logic                     start,
   input  logic                     stop,
   output logic [WIDTH-1:0]         freq_sel,
   output logic                     wave_sel,
   output logic [CNT_WIDTH-1:0]     duty_cyc,
   output logic                     gate,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = WIDTH + 1 + CNT_WIDTH + DUR_WIDTH;
   localparam int GW = $clog2(GAP_TICKS + 1);
   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
   state_t               state;
   logic [EW-1:0]        mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [WIDTH-1:0]     head_freq;
   logic                 head_wave;
   logic [CNT_WIDTH-1:0] head_duty;
   logic [DUR_WIDTH-1:0] head_dur, dur_cnt;
   logic [GW-1:0]        gap_cnt;
   logic                 push, pop;
   assign note_ready = count < CW'(DEPTH);
   assign push = note_valid && note_ready;
   // a stop during LOAD aborts before the head is consumed, so the queue is retained
   assign pop = (state == LOAD) && !stop;
   assign {head_freq, head_wave, head_duty, head_dur} = mem[rd_ptr];
   assign busy = state != IDLE;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {note_freq, note_wave, note_duty, note_dur};
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         freq_sel <= '0;
         wave_sel <= 1'b0;
         duty_cyc <= '0;
         gate     <= 1'b0;
         done     <= 1'b0;
         dur_cnt  <= '0;
         gap_cnt  <= '0;
      end else if (stop) begin
         state <= IDLE;
         gate  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start && count != '0) state <= LOAD;
            LOAD: begin
               freq_sel <= head_freq;
               wave_sel <= head_wave;
               duty_cyc <= head_duty;
               dur_cnt  <= (head_dur == '0) ? DUR_WIDTH'(1) : head_dur;
               gate     <= 1'b1;
               state    <= PLAY;
            end
            PLAY: if (tick) begin
               dur_cnt <= dur_cnt - DUR_WIDTH'(1);
               if (dur_cnt == DUR_WIDTH'(1)) begin
                  gate    <= 1'b0;
                  gap_cnt <= GW'(GAP_TICKS);
                  state   <= GAP;
               end
            end
            GAP: if (tick) begin
               gap_cnt <= gap_cnt - GW'(1);
               if (gap_cnt == GW'(1)) begin
                  state <= (count != '0) ? LOAD : IDLE;
                  done  <= count == '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
